// File: rtl/pattern_resp_reader_if.sv
// Response bus from a merged pattern netlist to its reader: one word per
// valid/ready transfer.
interface pattern_resp_reader_if #(
  parameter int unsigned RESP_W = 8
) ();
  logic [RESP_W-1:0] resp_in;
  logic              resp_valid;
  logic              resp_ready;

  modport master (
    output resp_in,
    output resp_valid,
    input  resp_ready
  );

  modport slave (
    input  resp_in,
    input  resp_valid,
    output resp_ready
  );
endinterface

// File: rtl/pattern_resp_reader.sv
// Reader end of the pattern-graph vector interface: accepts a programmed number
// of response words, folds them into a MISR signature and keeps the raw words
// in a small show-ahead FIFO for the test controller.
module pattern_resp_reader #(
  parameter int unsigned      RESP_W = 8,
  parameter int unsigned      SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = 16'h0000,
  parameter int unsigned      DEPTH  = 4
) (
  input  logic                  blif_clk_net,
  input  logic                  blif_reset_net,
  input  logic                  start,
  input  logic [7:0]            num_vec,
  pattern_resp_reader_if.slave  resp,
  input  logic                  rd_en,
  output logic [RESP_W-1:0]     rd_data,
  output logic                  rd_empty,
  output logic [SIG_W-1:0]      sig_out,
  output logic                  busy,
  output logic                  done,
  output logic                  underflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthOcc = (PtrW + 1)'(DEPTH);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StDone    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       tgt_q, tgt_d;
  logic             und_q, und_d;

  logic [RESP_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     occ_q, occ_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             start_ok;
  logic             accept;
  logic             pop;
  logic [SIG_W-1:0] misr_next;
  logic [SIG_W-1:0] resp_ext;

  always_comb begin
    fifo_full  = (occ_q == DepthOcc);
    fifo_empty = (occ_q == '0);
    // Readiness only looks at registered state, so it never combinationally
    // follows resp_valid or a same-cycle pop.
    resp.resp_ready = (state_q == StCapture) && !fifo_full;
    accept     = resp.resp_valid && resp.resp_ready;
    pop        = rd_en && !fifo_empty;
    start_ok   = start && (state_q != StCapture);
    resp_ext   = SIG_W'(resp.resp_in);
    misr_next  = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ resp_ext;
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    und_d   = und_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          sig_d   = SEED;
          cnt_d   = '0;
          tgt_d   = num_vec;
          state_d = (num_vec == 8'd0) ? StDone : StCapture;
        end
      end
      StCapture: begin
        if (accept) begin
          sig_d = misr_next;
          cnt_d = cnt_q + 8'd1;
          if ((cnt_q + 8'd1) == tgt_q) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_ok) begin
      und_d = 1'b0;
    end
    if (rd_en && fifo_empty) begin
      und_d = 1'b1;
    end
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({accept, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state_q  <= StIdle;
      sig_q    <= SEED;
      cnt_q    <= '0;
      tgt_q    <= '0;
      und_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      und_q   <= und_d;
      occ_q   <= occ_d;
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: the occupancy counter alone decides what is valid.
  always_ff @(posedge blif_clk_net) begin
    if (accept && !blif_reset_net) begin
      mem_q[wr_ptr_q] <= resp.resp_in;
    end
  end

  assign rd_data   = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign rd_empty  = fifo_empty;
  assign sig_out   = sig_q;
  assign busy      = (state_q == StCapture);
  assign done      = (state_q == StDone);
  assign underflow = und_q;

endmodule

// File: tb/tb_pattern_resp_reader.sv
// Bench for pattern_resp_reader: table of capture runs plus hand-written
// sequences for back-pressure, underflow, mid-run start/reset and MSB feedback.
module tb_pattern_resp_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, start2;
  logic [7:0]  num_vec, num_vec2;
  logic        rd_en, rd_en2;
  logic [7:0]  rd_data, rd_data2;
  logic        rd_empty, rd_empty2;
  logic [15:0] sig_out, sig_out2;
  logic        busy, busy2, done, done2, underflow, underflow2;

  pattern_resp_reader_if #(.RESP_W(8)) rif ();
  pattern_resp_reader_if #(.RESP_W(8)) rif2 ();

  pattern_resp_reader dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .start          (start),
    .num_vec        (num_vec),
    .resp           (rif),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_empty       (rd_empty),
    .sig_out        (sig_out),
    .busy           (busy),
    .done           (done),
    .underflow      (underflow)
  );

  pattern_resp_reader #(.SEED(16'h8000)) dut2 (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .start          (start2),
    .num_vec        (num_vec2),
    .resp           (rif2),
    .rd_en          (rd_en2),
    .rd_data        (rd_data2),
    .rd_empty       (rd_empty2),
    .sig_out        (sig_out2),
    .busy           (busy2),
    .done           (done2),
    .underflow      (underflow2)
  );

  typedef struct {
    logic [7:0]       n;
    logic [3:0][7:0]  w;
    logic [15:0]      exp_sig;
  } vec_t;

  vec_t        tbl[5];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  sb[$];
  logic [15:0] sig_model;

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [7:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {8'h00, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    start   = 1'b1;
    num_vec = n;
    step();
    start   = 1'b0;
  endtask

  task automatic send(input logic [7:0] w);
    int b;
    b = 0;
    rif.resp_valid = 1'b1;
    rif.resp_in    = w;
    while (!rif.resp_ready && b < 50) begin
      step();
      b++;
    end
    if (!rif.resp_ready) begin
      chk("ready timeout", {31'd0, rif.resp_ready}, 1);
    end else begin
      sb.push_back(w);
      sig_model = misr(sig_model, w);
      step();
    end
    rif.resp_valid = 1'b0;
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      chk("rd_empty while data", {31'd0, rd_empty}, 0);
      chk("rd_data head", {24'd0, rd_data}, {24'd0, sb.pop_front()});
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    chk("rd_empty after drain", {31'd0, rd_empty}, 1);
    chk("rd_data zero when empty", {24'd0, rd_data}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{n: 8'd2, w: {8'h00, 8'h00, 8'h01, 8'hA5}, exp_sig: 16'h014B};
    tbl[1] = '{n: 8'd1, w: {8'h00, 8'h00, 8'h00, 8'hFF}, exp_sig: 16'h00FF};
    tbl[2] = '{n: 8'd3, w: {8'h00, 8'h00, 8'h00, 8'h80}, exp_sig: 16'h0200};
    tbl[3] = '{n: 8'd3, w: {8'h00, 8'hFF, 8'hFF, 8'hFF}, exp_sig: 16'h02FD};
    tbl[4] = '{n: 8'd4, w: {8'h08, 8'h04, 8'h02, 8'h01}, exp_sig: 16'h0000};

    rst = 1'b1;
    start = 1'b0; num_vec = 8'd0; rd_en = 1'b0;
    start2 = 1'b0; num_vec2 = 8'd0; rd_en2 = 1'b0;
    rif.resp_valid = 1'b0;  rif.resp_in = 8'h00;
    rif2.resp_valid = 1'b0; rif2.resp_in = 8'h00;
    step();
    step();
    rst = 1'b0;
    step();

    chk("reset rd_empty", {31'd0, rd_empty}, 1);
    chk("reset rd_data", {24'd0, rd_data}, 0);
    chk("reset sig", {16'd0, sig_out}, 0);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset ready", {31'd0, rif.resp_ready}, 0);
    chk("reset underflow", {31'd0, underflow}, 0);
    chk("reset sig seed8000", {16'd0, sig_out2}, 32'h8000);

    // Table-driven runs.
    for (int i = 0; i < 5; i++) begin
      do_start(tbl[i].n);
      sig_model = 16'h0000;
      chk("run busy", {31'd0, busy}, 1);
      for (int j = 0; j < int'(tbl[i].n); j++) begin
        chk("done before last", {31'd0, done}, 0);
        send(tbl[i].w[j]);
        chk("sig per accept", {16'd0, sig_out}, {16'd0, sig_model});
      end
      chk("run done", {31'd0, done}, 1);
      chk("run busy after", {31'd0, busy}, 0);
      chk("run ready after", {31'd0, rif.resp_ready}, 0);
      chk("run final sig", {16'd0, sig_out}, {16'd0, tbl[i].exp_sig});
      drain();
    end

    // Zero-length run goes straight to DONE.
    do_start(8'd0);
    chk("zero done", {31'd0, done}, 1);
    chk("zero busy", {31'd0, busy}, 0);
    chk("zero ready", {31'd0, rif.resp_ready}, 0);
    chk("zero sig", {16'd0, sig_out}, 0);

    // Back-pressure: 6 words into a 4-deep FIFO with valid held high.
    do_start(8'd6);
    sig_model = 16'h0000;
    rif.resp_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rif.resp_in = 8'h10 + 8'(k);
      chk("fill ready", {31'd0, rif.resp_ready}, 1);
      sb.push_back(rif.resp_in);
      sig_model = misr(sig_model, rif.resp_in);
      step();
    end
    rif.resp_in = 8'h14;
    chk("full ready low", {31'd0, rif.resp_ready}, 0);
    step();
    chk("stall ready low", {31'd0, rif.resp_ready}, 0);
    chk("stall not done", {31'd0, done}, 0);
    chk("stall sig held", {16'd0, sig_out}, {16'd0, sig_model});
    rd_en = 1'b1;
    chk("full ready low with rd_en", {31'd0, rif.resp_ready}, 0);
    chk("pop word0", {24'd0, rd_data}, {24'd0, sb.pop_front()});
    step();
    rd_en = 1'b0;
    chk("ready after pop", {31'd0, rif.resp_ready}, 1);
    sb.push_back(8'h14);
    sig_model = misr(sig_model, 8'h14);
    step();
    rif.resp_in = 8'h15;
    chk("refull ready low", {31'd0, rif.resp_ready}, 0);
    chk("not done after 5", {31'd0, done}, 0);
    rd_en = 1'b1;
    chk("pop word1", {24'd0, rd_data}, {24'd0, sb.pop_front()});
    step();
    rd_en = 1'b0;
    chk("ready after 2nd pop", {31'd0, rif.resp_ready}, 1);
    sb.push_back(8'h15);
    sig_model = misr(sig_model, 8'h15);
    step();
    rif.resp_valid = 1'b0;
    chk("bp done", {31'd0, done}, 1);
    chk("bp sig", {16'd0, sig_out}, {16'd0, sig_model});
    drain();

    // Underflow is sticky until the next accepted start.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("underflow set", {31'd0, underflow}, 1);
    step();
    chk("underflow sticky", {31'd0, underflow}, 1);
    do_start(8'd3);
    sig_model = 16'h0000;
    chk("underflow cleared", {31'd0, underflow}, 0);
    send(8'h5A);
    start   = 1'b1;
    num_vec = 8'd1;
    step();
    start   = 1'b0;
    chk("mid start sig", {16'd0, sig_out}, {16'd0, sig_model});
    chk("mid start busy", {31'd0, busy}, 1);
    send(8'h3C);
    chk("mid start not done", {31'd0, done}, 0);
    send(8'hC3);
    chk("mid start done", {31'd0, done}, 1);
    chk("mid start final sig", {16'd0, sig_out}, {16'd0, sig_model});
    drain();

    // Reset after 1 of 3 accepts.
    do_start(8'd3);
    sig_model = 16'h0000;
    send(8'h77);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    chk("abort busy", {31'd0, busy}, 0);
    chk("abort done", {31'd0, done}, 0);
    chk("abort sig", {16'd0, sig_out}, 0);
    chk("abort rd_empty", {31'd0, rd_empty}, 1);
    chk("abort rd_data", {24'd0, rd_data}, 0);
    chk("abort ready", {31'd0, rif.resp_ready}, 0);

    // MSB feedback on the SEED=0x8000 instance.
    start2   = 1'b1;
    num_vec2 = 8'd1;
    step();
    start2   = 1'b0;
    chk("seed8000 start sig", {16'd0, sig_out2}, 32'h8000);
    rif2.resp_valid = 1'b1;
    rif2.resp_in    = 8'h00;
    chk("seed8000 ready", {31'd0, rif2.resp_ready}, 1);
    step();
    rif2.resp_valid = 1'b0;
    chk("msb feedback sig", {16'd0, sig_out2}, 32'h1021);
    chk("msb feedback done", {31'd0, done2}, 1);
    chk("msb feedback fifo", {24'd0, rd_data2}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_resp_reader.md
Name: pattern_resp_reader

Overview:
- Reader end of the pattern-graph vector interface. Consumes the response bus that a merged pattern netlist drives.
- Accepts a programmed number of response words over a valid/ready handshake.
- Compacts the accepted words into a MISR signature.
- Buffers the raw words in a small show-ahead FIFO for readout by the test controller.

Parameters:
- RESP_W, 8, width of response word (matches the 8-output pattern block)
- SIG_W, 16, MISR signature width; must be >= RESP_W
- POLY, 16'h1021, MISR feedback polynomial (low SIG_W bits used)
- SEED, 16'h0000, signature value on reset and on start
- DEPTH, 4, raw-capture FIFO depth; power of 2, >= 2

Ports:
- blif_clk_net  in  1  single clock, rising edge
- blif_reset_net  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins capture run (honoured in IDLE or DONE only)
- num_vec  in  8  responses to accept in the run; sampled on accepted start
- resp_in  in  RESP_W  response word from pattern block
- resp_valid  in  1  resp_in valid
- resp_ready  out  1  reader can accept; transfer when resp_valid & resp_ready
- rd_en  in  1  pop FIFO head
- rd_data  out  RESP_W  FIFO head (show-ahead; 0 when empty)
- rd_empty  out  1  FIFO empty
- sig_out  out  SIG_W  current MISR signature
- busy  out  1  state == CAPTURE
- done  out  1  state == DONE
- underflow  out  1  sticky: rd_en while empty; cleared by reset or accepted start

Behaviour:
- Reset, synchronous: state=IDLE, sig_out=SEED, FIFO flushed (rd_empty=1, rd_data=0), vector count=0, underflow=0.
  - With reset: resp_ready=0, busy=0, done=0.
  - Reset mid-run aborts the run immediately with no partial signature retained. Reset wins over all other inputs.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE/DONE --start--> CAPTURE: sig_out<=SEED, count<=0, tgt<=num_vec, underflow<=0. The FIFO is NOT flushed; unread words survive.
  - IDLE/DONE --start with num_vec==0--> DONE directly, sig_out=SEED.
  - CAPTURE --accept making count==tgt--> DONE in the same edge. done asserts the cycle after the final accept.
  - DONE holds until start or reset. start during CAPTURE is ignored.
- Handshake:
  - resp_ready = (state==CAPTURE) & !fifo_full. Combinational from registered state; no dependence on resp_valid.
  - Accept = resp_valid & resp_ready.
  - On accept: the word is pushed to the FIFO, count increments, and the MISR updates, all in one edge.
  - Producer may hold resp_valid high across stalls; each accept consumes exactly one word.
- MISR per accept:
  - sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_extend(resp_in).
  - No update on cycles without accept.
- FIFO:
  - rd_en & !rd_empty pops the head; rd_data updates the next cycle.
  - rd_en & rd_empty: no pop; underflow<=1.
  - Push and pop in the same cycle are both performed, and occupancy is unchanged.
  - When full, resp_ready is low even if rd_en is high that cycle; readiness returns the cycle after the pop.
  - Pointers wrap modulo DEPTH. Occupancy counter is width log2(DEPTH)+1.
- Counting: count is 8-bit. A run accepts exactly tgt words, so count never exceeds tgt and never wraps.

Test Plan:
- Reset, then start with num_vec=2, SEED=0; accept 0xA5 then 0x01 -> sig_out=0x00A5 after the first accept, 0x014B after the second. done=1 the cycle after the second accept; FIFO reads return 0xA5 then 0x01, then rd_empty=1.
- start with num_vec=0 -> DONE the next cycle, sig_out=0x0000, resp_ready never asserted.
- num_vec=6, DEPTH=4, resp_valid held high, no reads:
  - resp_ready drops after 4 accepts.
  - Pulsing rd_en once pops 0th word and reasserts ready the following cycle.
  - Run completes only after 2 pops total.
- MSB feedback: SEED=16'h8000, one accept of 0x00 -> sig_out=0x1021.
- rd_en while empty -> underflow=1 and stays 1; the next accepted start clears it. start pulsed mid-CAPTURE -> no effect on count or sig.
- Reset asserted after 1 of 3 accepts -> next cycle state IDLE, sig_out=SEED, rd_empty=1, resp_ready=0.
